// File: rtl/data_memory_responder.sv
// data_memory_responder: CPU data-memory slave with 1 KiB byte-lane RAM and a 16-byte MMIO page
// Ports: clk, rst_n (sync, active-low); mem_addr/mem_size/mem_write/mem_read/mem_wdata from the core;
//        mem_rdata registered load data (right-aligned, zero-filled); sw board switches in;
//        leds LED register out; err sticky flags {illegal, misaligned}.
module data_memory_responder #(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] MMIO_BASE = 10'h3F0,
    parameter int                LED_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [2:0]        mem_size,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    input  logic [LED_W-1:0]  sw,
    output logic [LED_W-1:0]  leds,
    output logic [1:0]        err
);
    localparam int WORDS = 2 ** (ADDR_W - 2);

    logic [7:0]        lane [4][WORDS];
    logic [LED_W-1:0]  sw_s1, sw_s2;
    logic [31:0]       cnt;
    logic [1:0]        sz, off;
    logic [ADDR_W-3:0] idx;
    logic              is_mmio, misal, bad_size, bad, ro_wr, wr_ok, access;
    logic [3:0]        we;
    logic [31:0]       wword, rword, sh, ram_rd, mmio_rd, next_rd;
    logic              unused_size_bit;

    // funct3 bit 2 only selects sign/zero extension, which the core does itself
    assign unused_size_bit = mem_size[2];

    always_comb begin
        sz       = mem_size[1:0];
        idx      = mem_addr[ADDR_W-1:2];
        off      = mem_addr[3:2];
        is_mmio  = mem_addr >= MMIO_BASE;
        misal    = (sz == 2'd1 && mem_addr[0]) || (sz == 2'd2 && mem_addr[1:0] != 2'd0);
        bad_size = sz == 2'd3 || (is_mmio && sz != 2'd2);
        bad      = misal || bad_size;
        // odd word offsets (switches, reserved) are not writable
        ro_wr    = mem_write && is_mmio && off[0];
        wr_ok    = mem_write && !bad && !ro_wr;
        access   = mem_write || mem_read;
        we       = (!wr_ok || is_mmio) ? 4'b0000 :
                   sz == 2'd0 ? 4'b0001 << mem_addr[1:0] :
                   sz == 2'd1 ? (mem_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        // replicate narrow data onto every lane; we picks the lanes that take it
        wword    = sz == 2'd0 ? {4{mem_wdata[7:0]}} :
                   sz == 2'd1 ? {2{mem_wdata[15:0]}} : mem_wdata;
        rword    = {lane[3][idx], lane[2][idx], lane[1][idx], lane[0][idx]};
        sh       = rword >> {mem_addr[1:0], 3'b000};
        ram_rd   = sz == 2'd0 ? {24'd0, sh[7:0]} :
                   sz == 2'd1 ? {16'd0, sh[15:0]} : sh;
        mmio_rd  = off == 2'd0 ? {{(32-LED_W){1'b0}}, leds} :
                   off == 2'd1 ? {{(32-LED_W){1'b0}}, sw_s2} :
                   off == 2'd2 ? cnt : 32'd0;
        next_rd  = bad ? 32'd0 : is_mmio ? mmio_rd : ram_rd;
    end

    // RAM is deliberately not reset
    always_ff @(posedge clk) begin
        for (int j = 0; j < 4; j++)
            if (we[j]) lane[j][idx] <= wword[8*j +: 8];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_rdata <= 32'd0;
            leds      <= '0;
            err       <= 2'b00;
            cnt       <= 32'd0;
            sw_s1     <= '0;
            sw_s2     <= '0;
        end else begin
            mem_rdata <= next_rd;
            sw_s1     <= sw;
            sw_s2     <= sw_s1;
            cnt       <= (wr_ok && is_mmio && off == 2'd2) ? mem_wdata : cnt + 32'd1;
            if (wr_ok && is_mmio && off == 2'd0)
                leds <= mem_wdata[LED_W-1:0];
            err <= err | {access && (bad_size || ro_wr), access && misal};
        end
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed plus randomized check against a byte-level reference model
module tb_data_memory_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  mem_addr = '0;
    logic [2:0]  mem_size = '0;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic [9:0]  sw = '0;
    logic [9:0]  leds;
    logic [1:0]  err;

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_mem [1024];
    bit          m_val [1024];
    logic [9:0]  m_leds = '0;
    logic [1:0]  m_err = '0;
    logic [31:0] m_cnt = '0;
    logic [9:0]  m_sw1 = '0, m_sw2 = '0;

    data_memory_responder dut (
        .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_size(mem_size),
        .mem_write(mem_write), .mem_read(mem_read), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .sw(sw), .leds(leds), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // one bus cycle: drive, predict, clock, update model, compare
    task automatic step(input logic [9:0] a, input logic [2:0] s, input logic w, input logic r,
                        input logic [31:0] d);
        logic [31:0] exp;
        bit def, mis, bad, ro, mm;
        int n, sz, off;
        mem_addr = a; mem_size = s; mem_write = w; mem_read = r; mem_wdata = d;
        sz  = int'(s[1:0]);
        n   = 1 << sz;
        mm  = a >= 10'h3F0;
        off = mm ? (int'(a) - 'h3F0) / 4 : 0;
        mis = (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0);
        bad = sz == 3 || mis || (mm && sz != 2);
        ro  = mm && w && (off == 1 || off == 3);
        def = 1;
        exp = 0;
        if (!bad) begin
            if (mm)
                exp = off == 0 ? 32'(m_leds) : off == 1 ? 32'(m_sw2) : off == 2 ? m_cnt : 32'd0;
            else
                for (int i = 0; i < n; i++) begin
                    exp |= 32'(m_mem[int'(a) + i]) << (8 * i);
                    def &= m_val[int'(a) + i];
                end
        end
        @(posedge clk);
        if (!rst_n) begin
            m_leds = '0; m_err = '0; m_cnt = '0; m_sw1 = '0; m_sw2 = '0;
            exp = 0; def = 1;
        end else begin
            if (w || r) begin
                if (mis) m_err[0] = 1'b1;
                if (sz == 3 || (mm && sz != 2) || ro) m_err[1] = 1'b1;
            end
            if (w && !bad && !ro && mm && off == 2) m_cnt = d;
            else m_cnt = m_cnt + 1;
            if (w && !bad && !ro) begin
                if (mm) begin
                    if (off == 0) m_leds = d[9:0];
                end else
                    for (int i = 0; i < n; i++) begin
                        m_mem[int'(a) + i] = d[8*i +: 8];
                        m_val[int'(a) + i] = 1;
                    end
            end
            m_sw2 = m_sw1;
            m_sw1 = sw;
        end
        #1;
        if (def) check("rdata", mem_rdata, exp);
        check("leds", 32'(leds), 32'(m_leds));
        check("err", 32'(err), 32'(m_err));
    endtask

    initial begin
        rst_n = 1'b0;
        step(10'h000, 3'd2, 1'b0, 1'b0, 32'd0);
        step(10'h000, 3'd2, 1'b0, 1'b0, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_leds", 32'(leds), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        step(10'h010, 3'd2, 1'b1, 1'b0, 32'hDEADBEEF);
        step(10'h010, 3'd2, 1'b0, 1'b1, 32'd0);
        check("ld_word", mem_rdata, 32'hDEADBEEF);
        step(10'h013, 3'd4, 1'b0, 1'b1, 32'd0);
        check("ld_byte", mem_rdata, 32'h000000DE);
        step(10'h012, 3'd5, 1'b0, 1'b1, 32'd0);
        check("ld_half", mem_rdata, 32'h0000DEAD);
        step(10'h011, 3'd0, 1'b1, 1'b0, 32'h0000005A);
        step(10'h010, 3'd2, 1'b0, 1'b1, 32'd0);
        check("st_byte", mem_rdata, 32'hDEAD5AEF);

        step(10'h020, 3'd2, 1'b1, 1'b0, 32'h11223344);
        step(10'h021, 3'd1, 1'b1, 1'b0, 32'h0000AAAA);
        step(10'h022, 3'd2, 1'b1, 1'b0, 32'hCAFEF00D);
        check("misal_err", 32'(err), 32'h1);
        step(10'h023, 3'd1, 1'b0, 1'b1, 32'd0);
        check("misal_rd", mem_rdata, 32'd0);
        check("misal_err2", 32'(err), 32'h1);
        step(10'h020, 3'd2, 1'b0, 1'b1, 32'd0);
        check("misal_noram", mem_rdata, 32'h11223344);

        step(10'h3F0, 3'd2, 1'b1, 1'b0, 32'h000003FF);
        check("led_wr", 32'(leds), 32'h3FF);
        step(10'h3F0, 3'd0, 1'b1, 1'b0, 32'h00000000);
        check("led_byte", 32'(leds), 32'h3FF);
        check("led_byte_err", 32'(err), 32'h3);

        rst_n = 1'b0;
        step(10'h3F8, 3'd2, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) step(10'h3F8, 3'd2, 1'b0, 1'b1, 32'd0);
        check("cnt_10", mem_rdata, 32'd9);
        step(10'h3F8, 3'd2, 1'b1, 1'b1, 32'hFFFFFFFE);
        step(10'h3F8, 3'd2, 1'b0, 1'b1, 32'd0);
        check("cnt_ld", mem_rdata, 32'hFFFFFFFE);
        step(10'h3F8, 3'd2, 1'b0, 1'b1, 32'd0);
        check("cnt_max", mem_rdata, 32'hFFFFFFFF);
        step(10'h3F8, 3'd2, 1'b0, 1'b1, 32'd0);
        check("cnt_wrap", mem_rdata, 32'd0);

        for (int k = 0; k < 3; k++) step(10'h3F4, 3'd2, 1'b0, 1'b1, 32'd0);
        sw = 10'h155;
        step(10'h3F4, 3'd2, 1'b0, 1'b1, 32'd0);
        step(10'h3F4, 3'd2, 1'b0, 1'b1, 32'd0);
        check("sw_early", mem_rdata, 32'd0);
        step(10'h3F4, 3'd2, 1'b0, 1'b1, 32'd0);
        check("sw_sync", mem_rdata, 32'h155);

        rst_n = 1'b0;
        step(10'h3F4, 3'd2, 1'b0, 1'b1, 32'd0);
        check("rst2_rdata", mem_rdata, 32'd0);
        check("rst2_leds", 32'(leds), 32'd0);
        check("rst2_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 3000; k++) begin
            logic [9:0] a;
            logic       w;
            case ($urandom_range(0, 2))
                0:       a = 10'($urandom_range(0, 31));
                1:       a = 10'h3F0 + 10'($urandom_range(0, 15));
                default: a = 10'($urandom_range(0, 1023));
            endcase
            rst_n = $urandom_range(0, 199) != 0;
            if ($urandom_range(0, 15) == 0) sw = 10'($urandom);
            w = rst_n && $urandom_range(0, 2) == 0;
            step(a, 3'($urandom_range(0, 7)), w, 1'($urandom), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
